fir_mac_scheduler: RTL

//  Controller that time-shares one serial multiply-accumulate FIR datapath between NUM_CH sample channels.

---
 rtl/fir_sched_pkg.sv | 37 +++
 rtl/fir_rr_arbiter.sv | 42 ++++
 rtl/fir_mac_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fir_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_sched_pkg                                                   |
// | Purpose  : Shared types and width helpers for the FIR MAC scheduler.       |
// |            state_e enumerates the controller states; the width functions   |
// |            derive channel, tap and sample-RAM address widths.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fir_sched_pkg;

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_GRANT = 3'd2,
      S_MAC   = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   function automatic int ch_width(input int num_ch);
      return $clog2(num_ch);
   endfunction

   function automatic int k_width(input int taps);
      return $clog2(taps);
   endfunction

   function automatic int addr_width(input int num_ch, input int taps);
      return $clog2(num_ch * taps);
   endfunction

   // Number of distinct coefficients stored when the filter is symmetric.
   function automatic int symm_half(input int taps);
      return (taps + 1) / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_rr_arbiter                                                  |
// | Purpose  : Combinational round-robin pick. The search starts at the        |
// |            channel after last_i and wraps.                                 |
// | Ports    : req_i  [NUM_CH] request vector                                  |
// |            last_i [CH_W]   most recently granted channel                   |
// |            gnt_o  [NUM_CH] one-hot grant (zero when no request)            |
// |            idx_o  [CH_W]   index of the granted channel                    |
// |            any_o           at least one request present                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fir_rr_arbiter
   import fir_sched_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   last_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [CH_W-1:0]   idx_o,
   output logic              any_o
);

   assign any_o = |req_i;

   // Walk from the farthest candidate to the nearest; the nearest requester
   // after last_i is written last and therefore wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         if (req_i[(int'(last_i) + i) % NUM_CH]) begin
            gnt_o = NUM_CH'(1) << ((int'(last_i) + i) % NUM_CH);
            idx_o = CH_W'((int'(last_i) + i) % NUM_CH);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fir_mac_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_mac_scheduler                                               |
// | Purpose  : Time-shares one serial MAC FIR datapath between NUM_CH channels.|
// |            After reset, zeroes the sample RAM (INIT sweep), then serves    |
// |            channel requests round-robin: writes the sample into the        |
// |            channel's ring region and sequences TAPS MAC steps.             |
// | Ports    : clk, syn_rst (sync, active-high), clk_enable (freeze)           |
// |            ch_req/ch_ack       channel handshake                           |
// |            wr_en/wr_zero/wr_addr  sample RAM write port                    |
// |            rd_addr, coeff_addr    sample RAM / coefficient ROM addresses   |
// |            mac_first/mac_last     accumulator control                      |
// |            out_valid/out_ch       result qualifier, busy = not IDLE        |
// | Macro    : FIR_SCHED_SYMM_EN - symmetric coefficients, half-size ROM       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fir_mac_scheduler
   import fir_sched_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int TAPS   = 6,
   localparam int CH_W   = ch_width(NUM_CH),
   localparam int K_W    = k_width(TAPS),
   localparam int ADDR_W = addr_width(NUM_CH, TAPS)
) (
   input  logic              clk,
   input  logic              syn_rst,
   input  logic              clk_enable,
   input  logic [NUM_CH-1:0] ch_req,
   output logic [NUM_CH-1:0] ch_ack,
   output logic              wr_en,
   output logic              wr_zero,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [K_W-1:0]    coeff_addr,
   output logic              mac_first,
   output logic              mac_last,
   output logic              out_valid,
   output logic [CH_W-1:0]   out_ch,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(NUM_CH * TAPS - 1);
   localparam logic [K_W-1:0]    K_LAST    = K_W'(TAPS - 1);
   localparam logic [K_W-1:0]    K_HALF    = K_W'(symm_half(TAPS));

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [CH_W-1:0]     rr_q, rr_d;
   logic [K_W-1:0]      ptr_q [NUM_CH];
   logic [K_W-1:0]      ptr_d [NUM_CH];

   logic [NUM_CH-1:0]   arb_gnt;
   logic [CH_W-1:0]     arb_idx;
   logic                arb_any;
   logic [K_W-1:0]      grant_ptr;
   logic [K_W-1:0]      cur_ptr;

   function automatic logic [K_W-1:0] ptr_inc(input logic [K_W-1:0] p);
      return (p == K_LAST) ? '0 : p + K_W'(1);
   endfunction

   // (p - k) mod TAPS without a divider; k <= TAPS-1 always.
   function automatic logic [K_W-1:0] ptr_sub(input logic [K_W-1:0] p, input logic [K_W-1:0] k);
      return (p >= k) ? p - k : K_W'(TAPS) - (k - p);
   endfunction

   function automatic logic [ADDR_W-1:0] ring_addr(input logic [CH_W-1:0] c, input logic [K_W-1:0] p);
      return ADDR_W'(c) * ADDR_W'(TAPS) + ADDR_W'(p);
   endfunction

   fir_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req_i  (ch_req),
      .last_i (rr_q),
      .gnt_o  (arb_gnt),
      .idx_o  (arb_idx),
      .any_o  (arb_any)
   );

   assign grant_ptr = ptr_inc(ptr_q[arb_idx]);
   assign cur_ptr   = ptr_q[ch_q];
   assign busy      = (state_q != S_IDLE);

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      k_d        = k_q;
      ch_d       = ch_q;
      rr_d       = rr_q;
      ptr_d      = ptr_q;
      ch_ack     = '0;
      wr_en      = 1'b0;
      wr_zero    = 1'b0;
      wr_addr    = '0;
      rd_addr    = '0;
      coeff_addr = '0;
      mac_first  = 1'b0;
      mac_last   = 1'b0;
      out_valid  = 1'b0;
      out_ch     = '0;

      case (state_q)
         S_INIT: begin
            wr_en   = 1'b1;
            wr_zero = 1'b1;
            wr_addr = init_cnt_q;
            if (init_cnt_q == INIT_LAST) begin
               init_cnt_d = '0;
               state_d    = arb_any ? S_GRANT : S_IDLE;
            end else begin
               init_cnt_d = init_cnt_q + ADDR_W'(1);
            end
         end
         S_IDLE: begin
            if (arb_any) state_d = S_GRANT;
         end
         S_GRANT: begin
            // A request withdrawn before it was granted is simply dropped.
            if (arb_any) begin
               ch_d           = arb_idx;
               rr_d           = arb_idx;
               ptr_d[arb_idx] = grant_ptr;
               ch_ack         = arb_gnt;
               wr_en          = 1'b1;
               wr_addr        = ring_addr(arb_idx, grant_ptr);
               k_d            = '0;
               state_d        = S_MAC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MAC: begin
            rd_addr   = ring_addr(ch_q, ptr_sub(cur_ptr, k_q));
`ifdef FIR_SCHED_SYMM_EN
            coeff_addr = (k_q < K_HALF) ? k_q : K_LAST - k_q;
`else
            coeff_addr = k_q;
`endif
            mac_first = (k_q == '0);
            mac_last  = (k_q == K_LAST);
            if (k_q == K_LAST) state_d = S_DONE;
            else               k_d     = k_q + K_W'(1);
         end
         S_DONE: begin
            out_valid = 1'b1;
            out_ch    = ch_q;
            state_d   = arb_any ? S_GRANT : S_IDLE;
         end
         default: state_d = S_INIT;
      endcase

      // A frozen or resetting cycle must not disturb the RAM, ROM or MAC.
      if (!clk_enable || syn_rst) begin
         ch_ack     = '0;
         wr_en      = 1'b0;
         wr_zero    = 1'b0;
         wr_addr    = '0;
         rd_addr    = '0;
         coeff_addr = '0;
         mac_first  = 1'b0;
         mac_last   = 1'b0;
         out_valid  = 1'b0;
         out_ch     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (syn_rst) begin
         state_q    <= S_INIT;
         init_cnt_q <= '0;
         k_q        <= '0;
         ch_q       <= '0;
         rr_q       <= CH_W'(NUM_CH - 1);
         for (int i = 0; i < NUM_CH; i++) ptr_q[i] <= '0;
      end else if (clk_enable) begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         k_q        <= k_d;
         ch_q       <= ch_d;
         rr_q       <= rr_d;
         ptr_q      <= ptr_d;
      end
   end

   // K_HALF is only consumed in the symmetric build.
   logic unused_ok;
   assign unused_ok = ^K_HALF;

endmodule
`default_nettype wire
